// File: rtl/parking_gate_arbiter_if.sv
// Request/grant and occupancy-display bundle for the shared car park barrier.
// The master side is the entry/exit request logic together with the display
// logic that reads occupancy; the slave side is the arbiter.
interface parking_gate_arbiter_if #(
  parameter int NUM_SLOTS = 5
);
  logic                 entry_req;
  logic                 entry_ack;
  logic [2:0]           entry_slot;
  logic                 exit_req;
  logic [2:0]           exit_slot;
  logic                 exit_ack;
  logic                 exit_err;
  logic                 gate_open;
  logic [NUM_SLOTS-1:0] slots_available;
  logic [3:0]           free_count;
  logic                 full;

  modport master (
    output entry_req,
    output exit_req,
    output exit_slot,
    input  entry_ack,
    input  entry_slot,
    input  exit_ack,
    input  exit_err,
    input  gate_open,
    input  slots_available,
    input  free_count,
    input  full
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    input  exit_slot,
    output entry_ack,
    output entry_slot,
    output exit_ack,
    output exit_err,
    output gate_open,
    output slots_available,
    output free_count,
    output full
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier controller with slot pool.
// Entry and exit requests are arbitrated round-robin in IDLE only. An entry
// takes the lowest free slot and an exit frees the named slot. The barrier
// then stays raised for GATE_TICKS pulses of the 100 Hz tick. Every output is
// a register; the occupancy summary is computed from next-state occupancy so
// that it changes on the same edge as the occupancy itself.
module parking_gate_arbiter #(
  parameter int NUM_SLOTS  = 5,
  parameter int GATE_TICKS = 200
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   tick,
  parking_gate_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY_OPEN = 2'd1,
    ST_EXIT_OPEN  = 2'd2
  } gate_state_t;

  // Number of set bits in an occupancy vector.
  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt = cnt + {3'd0, vec[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest clear bit; only meaningful when one exists.
  function automatic logic [2:0] lowest_free(input logic [NUM_SLOTS-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  gate_state_t          state_r, state_s;
  logic [NUM_SLOTS-1:0] occupied_r, occupied_s;
  logic [9:0]           timer_r, timer_s;
  logic                 last_grant_r, last_grant_s;
  logic [2:0]           entry_slot_r, entry_slot_s;
  logic                 entry_ack_r, entry_ack_s;
  logic                 exit_ack_r, exit_ack_s;
  logic                 exit_err_r, exit_err_s;
  logic                 gate_open_r, gate_open_s;
  logic [NUM_SLOTS-1:0] slots_available_r;
  logic [3:0]           free_count_r, free_count_s;
  logic                 full_r;

  logic                 exit_slot_occ_s;
  logic                 entry_elig_s;
  logic                 exit_elig_s;
  logic                 grant_entry_s;
  logic                 grant_exit_s;

  // Look up whether the named exit slot exists and is currently occupied.
  always_comb begin
    exit_slot_occ_s = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.exit_slot == 3'(i)) begin
        exit_slot_occ_s = occupied_r[i];
      end else begin
        exit_slot_occ_s = exit_slot_occ_s;
      end
    end
  end

  // Eligibility and round-robin tie break; last_grant_r = 1 means exit went last.
  always_comb begin
    entry_elig_s  = bus.entry_req && !full_r;
    exit_elig_s   = bus.exit_req && exit_slot_occ_s;
    grant_entry_s = 1'b0;
    grant_exit_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_entry_s = entry_elig_s && (!exit_elig_s || last_grant_r);
      grant_exit_s  = exit_elig_s && !grant_entry_s;
    end else begin
      grant_entry_s = 1'b0;
      grant_exit_s  = 1'b0;
    end
  end

  // Next-state and next-output logic for the barrier FSM.
  always_comb begin
    state_s      = state_r;
    occupied_s   = occupied_r;
    timer_s      = timer_r;
    last_grant_s = last_grant_r;
    entry_slot_s = entry_slot_r;
    gate_open_s  = gate_open_r;
    entry_ack_s  = 1'b0;
    exit_ack_s   = 1'b0;
    exit_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        exit_err_s = bus.exit_req && !exit_elig_s;
        if (grant_entry_s) begin
          entry_slot_s = lowest_free(occupied_r);
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (entry_slot_s == 3'(i)) begin
              occupied_s[i] = 1'b1;
            end else begin
              occupied_s[i] = occupied_r[i];
            end
          end
          entry_ack_s  = 1'b1;
          gate_open_s  = 1'b1;
          timer_s      = 10'(GATE_TICKS);
          last_grant_s = 1'b0;
          state_s      = ST_ENTRY_OPEN;
        end else if (grant_exit_s) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.exit_slot == 3'(i)) begin
              occupied_s[i] = 1'b0;
            end else begin
              occupied_s[i] = occupied_r[i];
            end
          end
          exit_ack_s   = 1'b1;
          gate_open_s  = 1'b1;
          timer_s      = 10'(GATE_TICKS);
          last_grant_s = 1'b1;
          state_s      = ST_EXIT_OPEN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
        // Requests are ignored while the barrier is raised.
        if (tick) begin
          if (timer_r == 10'd1) begin
            timer_s     = 10'd0;
            gate_open_s = 1'b0;
            state_s     = ST_IDLE;
          end else begin
            timer_s = timer_r - 10'd1;
          end
        end else begin
          timer_s = timer_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        timer_s     = 10'd0;
        gate_open_s = 1'b0;
      end
    endcase
  end

  // Free-slot count of the occupancy that will be registered on this edge.
  always_comb begin
    free_count_s = 4'(NUM_SLOTS) - popcount(occupied_s);
  end

  // State, occupancy and registered outputs; reset also closes the gate.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      occupied_r        <= '0;
      timer_r           <= 10'd0;
      last_grant_r      <= 1'b1;
      entry_slot_r      <= 3'd0;
      entry_ack_r       <= 1'b0;
      exit_ack_r        <= 1'b0;
      exit_err_r        <= 1'b0;
      gate_open_r       <= 1'b0;
      slots_available_r <= '1;
      free_count_r      <= 4'(NUM_SLOTS);
      full_r            <= 1'b0;
    end else begin
      state_r           <= state_s;
      occupied_r        <= occupied_s;
      timer_r           <= timer_s;
      last_grant_r      <= last_grant_s;
      entry_slot_r      <= entry_slot_s;
      entry_ack_r       <= entry_ack_s;
      exit_ack_r        <= exit_ack_s;
      exit_err_r        <= exit_err_s;
      gate_open_r       <= gate_open_s;
      slots_available_r <= ~occupied_s;
      free_count_r      <= free_count_s;
      full_r            <= (free_count_s == 4'd0);
    end
  end

  assign bus.entry_ack       = entry_ack_r;
  assign bus.entry_slot      = entry_slot_r;
  assign bus.exit_ack        = exit_ack_r;
  assign bus.exit_err        = exit_err_r;
  assign bus.gate_open       = gate_open_r;
  assign bus.slots_available = slots_available_r;
  assign bus.free_count      = free_count_r;
  assign bus.full            = full_r;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a slot-list reference model.
module tb_parking_gate_arbiter;

  localparam int NS = 5;
  localparam int GT = 3;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  parking_gate_arbiter_if #(.NUM_SLOTS(NS)) bus ();

  parking_gate_arbiter #(.NUM_SLOTS(NS), .GATE_TICKS(GT)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .tick  (tick),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: car list per slot, ticks remaining while the barrier is up.
  bit m_occ[NS];
  int m_left;
  bit m_exit_last;
  int m_slot;
  bit m_eack, m_xack, m_err;

  // Held request levels used while waiting for the barrier.
  logic       h_er = 1'b0;
  logic       h_xr = 1'b0;
  logic [2:0] h_xs = 3'd0;

  function automatic int m_free();
    int c;
    c = 0;
    for (int i = 0; i < NS; i++) if (!m_occ[i]) c++;
    return c;
  endfunction

  function automatic logic [NS-1:0] m_avail();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = !m_occ[i];
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic er, input logic xr, input logic [2:0] xs,
                            input logic tk, input logic rn);
    bit e_ok, x_ok, take_entry;
    int k;
    m_eack = 1'b0;
    m_xack = 1'b0;
    m_err  = 1'b0;
    if (!rn) begin
      for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
      m_left = 0;
      m_exit_last = 1'b1;
      m_slot = 0;
    end else if (m_left > 0) begin
      if (tk) m_left--;
    end else begin
      e_ok = er && (m_free() > 0);
      x_ok = xr && (int'(xs) < NS) && m_occ[int'(xs) % NS];
      m_err = xr && !x_ok;
      take_entry = e_ok && (!x_ok || m_exit_last);
      if (take_entry) begin
        k = 0;
        while (m_occ[k]) k++;
        m_occ[k] = 1'b1;
        m_slot = k;
        m_eack = 1'b1;
        m_left = GT;
        m_exit_last = 1'b0;
      end else if (x_ok) begin
        m_occ[int'(xs)] = 1'b0;
        m_xack = 1'b1;
        m_left = GT;
        m_exit_last = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check_eq("gate_open", bus.gate_open, (m_left > 0));
    check_eq("entry_ack", bus.entry_ack, m_eack);
    check_eq("exit_ack", bus.exit_ack, m_xack);
    check_eq("exit_err", bus.exit_err, m_err);
    check_eq("entry_slot", bus.entry_slot, m_slot);
    check_eq("slots_available", bus.slots_available, m_avail());
    check_eq("free_count", bus.free_count, m_free());
    check_eq("full", bus.full, (m_free() == 0));
  endtask

  // One clock: drive at the falling edge, step the model, compare after the rise.
  task automatic cyc(input logic er, input logic xr, input logic [2:0] xs,
                     input logic tk, input logic rn);
    bus.entry_req = er;
    bus.exit_req  = xr;
    bus.exit_slot = xs;
    tick          = tk;
    rst_n         = rn;
    model_step(er, xr, xs, tk, rn);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  // Run with held requests until the barrier drops; tick every 'period' cycles.
  task automatic gate_run(input int period, output int ticks);
    int n;
    logic tk;
    ticks = 0;
    n = 0;
    while (bus.gate_open === 1'b1 && n < 500) begin
      tk = ((n % period) == 0);
      cyc(h_er, h_xr, h_xs, tk, 1'b1);
      if (tk) ticks++;
      n++;
    end
    check_eq("gate_close_bound", bus.gate_open, 1'b0);
  endtask

  initial begin
    int t;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.exit_slot = 3'd0;
    @(negedge clock);

    // Reset state.
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_eq("rst_free", bus.free_count, NS);
    check_eq("rst_avail", bus.slots_available, {NS{1'b1}});
    check_eq("rst_gate", bus.gate_open, 1'b0);
    check_eq("rst_full", bus.full, 1'b0);

    // First entry: slot 0, gate held for GT ticks.
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("e1_ack", bus.entry_ack, 1'b1);
    check_eq("e1_slot", bus.entry_slot, 0);
    check_eq("e1_avail", bus.slots_available, 5'b11110);
    check_eq("e1_free", bus.free_count, 4);
    check_eq("e1_gate", bus.gate_open, 1'b1);
    gate_run(1, t);
    check_eq("e1_ticks", t, GT);

    // Fill remaining slots in order.
    for (int k = 1; k < NS; k++) begin
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
      check_eq("fill_slot", bus.entry_slot, k);
      gate_run(1, t);
    end
    check_eq("fill_full", bus.full, 1'b1);
    check_eq("fill_free", bus.free_count, 0);

    // Entry while full waits silently.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
      check_eq("full_noack", bus.entry_ack, 1'b0);
    end
    cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    check_eq("x2_ack", bus.exit_ack, 1'b1);
    check_eq("x2_noentry", bus.entry_ack, 1'b0);
    h_er = 1'b1; h_xr = 1'b0;
    gate_run(2, t);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("held_entry_ack", bus.entry_ack, 1'b1);
    check_eq("held_entry_slot", bus.entry_slot, 2);
    h_er = 1'b0;
    gate_run(1, t);

    // Free slots 4 and 3, then two ties to show alternation.
    cyc(1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    gate_run(1, t);
    cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    gate_run(1, t);
    cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    check_eq("tie1_entry", bus.entry_ack, 1'b1);
    check_eq("tie1_noexit", bus.exit_ack, 1'b0);
    h_er = 1'b1; h_xr = 1'b1; h_xs = 3'd0;
    gate_run(1, t);
    cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    check_eq("tie2_exit", bus.exit_ack, 1'b1);
    check_eq("tie2_noentry", bus.entry_ack, 1'b0);
    h_er = 1'b0; h_xr = 1'b0;
    gate_run(1, t);

    // Invalid exits: free slot, then out-of-range slot.
    cyc(1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    check_eq("err_free_slot", bus.exit_err, 1'b1);
    check_eq("err_free_noack", bus.exit_ack, 1'b0);
    check_eq("err_free_cnt", bus.free_count, 2);
    cyc(1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
    check_eq("err_range", bus.exit_err, 1'b1);
    check_eq("err_range_avail", bus.slots_available, 5'b10001);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("err_clear", bus.exit_err, 1'b0);

    // Tick coincident with grant is not counted; sparse ticks every 4 cycles.
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    check_eq("sp_grant", bus.entry_ack, 1'b1);
    t = 0;
    for (int n = 1; n < 200 && bus.gate_open === 1'b1; n++) begin
      cyc(1'b0, 1'b0, 3'd0, ((n % 4) == 0), 1'b1);
      if ((n % 4) == 0) begin
        t++;
        if (t < GT) check_eq("sp_still_open", bus.gate_open, 1'b1);
        else check_eq("sp_close", bus.gate_open, 1'b0);
      end
    end
    check_eq("sp_ticks", t, GT);

    // Reset during EXIT_OPEN with three slots occupied.
    cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    check_eq("rx_ack", bus.exit_ack, 1'b1);
    check_eq("rx_free", bus.free_count, 2);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_eq("rx_gate", bus.gate_open, 1'b0);
    check_eq("rx_free_rst", bus.free_count, NS);
    check_eq("rx_full", bus.full, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("rx_idle_grant", bus.entry_ack, 1'b1);
    check_eq("rx_idle_slot", bus.entry_slot, 0);
    gate_run(1, t);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Controller for the car park's single shared entry/exit barrier and its slot pool. It accepts car entry and exit requests and arbitrates between them round-robin. It allocates the lowest-numbered free slot on entry and frees the named slot on exit. It holds the barrier open for a programmed number of 100 Hz ticks and publishes occupancy (slot LEDs, free count, FULL flag) to the seven-segment/LED display logic.

## Interface
- NUM_SLOTS, 5, number of parking slots; legal range 1..8
- GATE_TICKS, 200, barrier-open duration in `tick` pulses; legal range 1..1023
- clock  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  single-cycle 100 Hz enable pulse from the slow-clock divider
- entry_req  in  1  level; car at entry wants a slot
- entry_ack  out  1  one-cycle pulse; entry granted
- entry_slot  out  3  index of slot allocated at last entry grant; held until next entry grant
- exit_req  in  1  level; car at exit leaving slot `exit_slot`
- exit_slot  in  3  slot being vacated; sampled with exit_req
- exit_ack  out  1  one-cycle pulse; exit granted
- exit_err  out  1  high while an invalid exit request is presented in IDLE
- gate_open  out  1  barrier drive, 1 = raised
- slots_available  out  NUM_SLOTS  bit i = 1 when slot i is free
- free_count  out  4  number of free slots
- full  out  1  1 when free_count == 0; drives FULL/OPEn selection

## Operation
- State machine: IDLE, ENTRY_OPEN, EXIT_OPEN. Register `occupied[NUM_SLOTS-1:0]`, gate timer (10 bit), `last_grant` (0 = entry, 1 = exit).
- Requests are evaluated only in IDLE. They are ignored in both OPEN states; no queuing.
- Entry eligible: entry_req && !full.
- Exit eligible: exit_req && exit_slot < NUM_SLOTS && occupied[exit_slot].
- exit_err is 1 in IDLE when exit_req is high and exit is not eligible, else 0. It is registered and follows the condition one cycle later.
- Entry request while full: no ack, no error. The request waits until a slot frees.
- Both eligible: grant the side opposite `last_grant`. `last_grant` resets to exit, so entry wins the first tie.
- Entry grant edge:
  - set occupied at the lowest free index and load entry_slot with it
  - pulse entry_ack
  - set gate_open = 1 and timer = GATE_TICKS
  - go to ENTRY_OPEN; last_grant = 0
- Exit grant edge:
  - clear occupied[exit_slot]
  - pulse exit_ack
  - set gate_open = 1 and timer = GATE_TICKS
  - go to EXIT_OPEN; last_grant = 1
- OPEN states: timer decrements on each cycle with tick = 1. On the edge where tick = 1 and timer == 1: gate_open = 0, state returns to IDLE.
- Requesters drop req in the cycle after ack. A request still held when IDLE is re-entered is treated as a new request.
- slots_available = ~occupied. free_count = NUM_SLOTS − popcount(occupied). full = (free_count == 0). All three are registered and updated on the same edge as the occupancy change.
- Reset values: state IDLE, occupied 0, last_grant 1, gate_open 0, entry_ack 0, exit_ack 0, exit_err 0, entry_slot 0, timer 0, slots_available all 1, free_count NUM_SLOTS, full 0.
- Reset asserted mid-OPEN: on that edge the gate closes and occupancy clears, with no ack pulse.

## Timing
- Grant latency: request high before edge N in IDLE → ack, gate_open, and occupancy/free_count/full all change after edge N. Ack is high for exactly cycle N..N+1.
- Gate open time: exactly GATE_TICKS tick pulses, counted from the first tick after the grant edge. A tick coincident with the grant cycle is not counted.
- After gate_open falls at edge M, the earliest next grant is edge M+1.
- Back-to-back grants never overlap; gate_open never glitches low between two grants of zero spacing (minimum 1 cycle low).
- tick is ignored in IDLE.

## Test plan
- Reset, then entry_req for 1 cycle → entry_ack 1 cycle, entry_slot = 0, slots_available = 5'b11110, free_count = 4, gate_open high for 200 ticks then low.
- Five entries → slots 0,1,2,3,4 allocated in order, full = 1. Sixth entry_req held → no ack. exit_slot = 2 exit → exit_ack; after the gate cycle, the held entry is granted slot 2.
- entry_req and exit_req (slot 0 occupied) raised in the same cycle from IDLE → entry granted first. After the gate closes, exit granted. Repeat the tie → exit first this time (alternation).
- exit_req with exit_slot = 3 while slot 3 is free, then with exit_slot = 6 → exit_err = 1, no ack, occupancy unchanged.
- GATE_TICKS = 3, ticks every 4 cycles, one tick coincident with the grant cycle → gate_open falls on the edge of the third subsequent tick.
- rst_n low for 1 cycle during EXIT_OPEN with 3 slots occupied → next cycle gate_open = 0, free_count = 5, full = 0, state IDLE.
